// File: rtl/mux_pkg.sv
// Shared constants for the 1-to-4 dispatcher: channel count, select width,
// the consumer channel indices and the select-to-one-hot decode.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] CH_ALU = 2'd0;
  localparam logic [SEL_W-1:0] CH_MEM = 2'd1;
  localparam logic [SEL_W-1:0] CH_BR  = 2'd2;
  localparam logic [SEL_W-1:0] CH_CSR = 2'd3;

  function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] onehot;
    onehot = '0;
    case (sel)
      CH_ALU:  onehot = 4'b0001;
      CH_MEM:  onehot = 4'b0010;
      CH_BR:   onehot = 4'b0100;
      CH_CSR:  onehot = 4'b1000;
      default: onehot = '0;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/dispatch_slot.sv
// Single-entry output register for one dispatcher channel; it can accept a
// new beat whenever it is empty or its current beat leaves in the same cycle.
module dispatch_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_load
);

  assign can_load = !valid || drain_ready;

  // A load wins over a drain so a same-cycle drain+load keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && drain_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_dispatch.sv
// 1-to-4 valid/ready stream dispatcher with one registered slot per channel.
// Optional build macro DEMUX_STATS_EN adds per-channel transfer counters.
module demux_dispatch
  import mux_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [WIDTH-1:0]        i_data,
  output logic                    o_ready,
  output logic [NUM_CH-1:0]       o_valid,
  output logic [NUM_CH*WIDTH-1:0] o_data,
  input  logic [NUM_CH-1:0]       i_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] o_xfer_cnt
`endif
);

  logic [NUM_CH-1:0] can_load;
  logic [NUM_CH-1:0] load;
  logic [WIDTH-1:0]  slot_data [NUM_CH];

  // Ready looks only at the targeted slot, never at i_valid.
  assign o_ready = !i_rst && can_load[i_sel];
  assign load    = sel_decode(i_sel) & {NUM_CH{i_valid && o_ready}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    dispatch_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (i_clk),
      .rst         (i_rst),
      .load        (load[k]),
      .load_data   (i_data),
      .drain_ready (i_ready[k]),
      .valid       (o_valid[k]),
      .data        (slot_data[k]),
      .can_load    (can_load[k])
    );
    assign o_data[k*WIDTH +: WIDTH] = slot_data[k];
  end

`ifdef DEMUX_STATS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt <= '0;
      end else if (load[k]) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
    assign o_xfer_cnt[k*CNT_W +: CNT_W] = cnt;
  end
`endif

  // A stalled producer must hold its destination and payload.
  a_input_stable: assert property (
    @(posedge i_clk) disable iff (i_rst)
      (i_valid && !o_ready) |=> ($stable(i_sel) && $stable(i_data))
  );

endmodule

// File: tb/tb_demux_dispatch.sv
// Self-checking bench for demux_dispatch: table vectors, corner sequences and
// random traffic, all scored against per-channel expected-beat queues.
module tb_demux_dispatch;
  import mux_pkg::*;

  localparam int WIDTH = 32;
`ifdef DEMUX_STATS_EN
  localparam int CNT_W = 4;
`endif

  logic                    i_clk;
  logic                    i_rst;
  logic                    i_valid;
  logic [SEL_W-1:0]        i_sel;
  logic [WIDTH-1:0]        i_data;
  logic                    o_ready;
  logic [NUM_CH-1:0]       o_valid;
  logic [NUM_CH*WIDTH-1:0] o_data;
  logic [NUM_CH-1:0]       i_ready;
`ifdef DEMUX_STATS_EN
  logic [NUM_CH*CNT_W-1:0] o_xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sbq [NUM_CH][$];

  typedef struct {
    logic             v;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic [3:0]       rdy;
    logic             exp_ready;
  } vec_t;

  vec_t vecs [10];

  demux_dispatch #(
    .WIDTH(WIDTH)
`ifdef DEMUX_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_sel   (i_sel),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
`ifdef DEMUX_STATS_EN
    ,
    .o_xfer_cnt (o_xfer_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compares every channel against the head of its queue and o_ready against the model.
  task automatic checkOutput(output logic exp_rdy);
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("valid%0d", k), 128'(o_valid[k]), 128'(sbq[k].size() != 0));
      if (sbq[k].size() != 0)
        chk($sformatf("data%0d", k), 128'(o_data[k*WIDTH +: WIDTH]), 128'(sbq[k][0]));
    end
    exp_rdy = (sbq[i_sel].size() == 0) || i_ready[i_sel];
    chk("o_ready", 128'(o_ready), 128'(exp_rdy));
  endtask

  // Drives one cycle, scores it, then advances to just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] s,
                               input logic [WIDTH-1:0] d, input logic [3:0] r);
    logic exp_rdy;
    i_valid = v;
    i_sel   = s;
    i_data  = d;
    i_ready = r;
    #1;
    checkOutput(exp_rdy);
    for (int k = 0; k < NUM_CH; k++)
      if (sbq[k].size() != 0 && r[k]) void'(sbq[k].pop_front());
    if (v && exp_rdy) sbq[s].push_back(d);
    @(posedge i_clk);
    #1;
  endtask

  task automatic clearQueues();
    for (int k = 0; k < NUM_CH; k++) sbq[k].delete();
  endtask

  initial begin
    logic             hold;
    logic             rv;
    logic [SEL_W-1:0] rs;
    logic [WIDTH-1:0] rd;
    logic [3:0]       rr;

    vecs[0] = '{1'b1, CH_ALU, 32'hA000_0000, 4'b1111, 1'b1};
    vecs[1] = '{1'b1, CH_MEM, 32'hA000_0001, 4'b1111, 1'b1};
    vecs[2] = '{1'b1, CH_BR,  32'hA000_0002, 4'b1111, 1'b1};
    vecs[3] = '{1'b1, CH_CSR, 32'hA000_0003, 4'b1111, 1'b1};
    vecs[4] = '{1'b0, CH_ALU, 32'h0,         4'b1111, 1'b1};
    vecs[5] = '{1'b1, CH_MEM, 32'hB000_0001, 4'b0000, 1'b1};
    vecs[6] = '{1'b1, CH_MEM, 32'hB000_0002, 4'b0000, 1'b0};
    vecs[7] = '{1'b1, CH_MEM, 32'hB000_0002, 4'b0010, 1'b1};
    vecs[8] = '{1'b0, CH_ALU, 32'h0,         4'b1111, 1'b1};
    vecs[9] = '{1'b0, CH_MEM, 32'h0,         4'b1111, 1'b1};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_sel   = '0;
    i_data  = '0;
    i_ready = '0;
    #3;
    chk("reset_valid", 128'(o_valid), 128'(0));
    chk("reset_data",  128'(o_data),  128'(0));
    chk("reset_ready", 128'(o_ready), 128'(0));
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      i_sel   = vecs[i].sel;
      i_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_ready", i), 128'(o_ready), 128'(vecs[i].exp_ready));
      applyStimulus(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].rdy);
    end

    $display("[TB] single beat");
    applyStimulus(1'b1, CH_BR, 32'hDEAD_BEEF, 4'b1111);
    chk("single_valid", 128'(o_valid), 128'(4'b0100));
    chk("single_data",  128'(o_data[2*WIDTH +: WIDTH]), 128'(32'hDEAD_BEEF));
    applyStimulus(1'b0, CH_ALU, 32'h0, 4'b1111);
    chk("single_gone", 128'(o_valid), 128'(4'b0000));

    $display("[TB] backpressure");
    applyStimulus(1'b1, CH_MEM, 32'h11, 4'b0000);
    i_valid = 1'b1;
    i_sel   = CH_MEM;
    i_data  = 32'h22;
    i_ready = 4'b0000;
    #1;
    chk("bp_ready",  128'(o_ready), 128'(0));
    chk("bp_hold",   128'(o_data[1*WIDTH +: WIDTH]), 128'(32'h11));
    applyStimulus(1'b1, CH_CSR, 32'h33, 4'b0000);
    chk("bp_valid",  128'(o_valid), 128'(4'b1010));
    chk("bp_data3",  128'(o_data[3*WIDTH +: WIDTH]), 128'(32'h33));
    applyStimulus(1'b0, CH_ALU, 32'h0, 4'b1111);

    $display("[TB] same-channel drain and load");
    applyStimulus(1'b1, CH_ALU, 32'h1, 4'b0000);
    i_valid = 1'b1;
    i_sel   = CH_ALU;
    i_data  = 32'h2;
    i_ready = 4'b0001;
    #1;
    chk("dl_ready", 128'(o_ready), 128'(1));
    applyStimulus(1'b1, CH_ALU, 32'h2, 4'b0001);
    chk("dl_valid", 128'(o_valid[0]), 128'(1));
    chk("dl_data",  128'(o_data[0 +: WIDTH]), 128'(32'h2));
    applyStimulus(1'b0, CH_ALU, 32'h0, 4'b1111);

    $display("[TB] random traffic");
    hold = 1'b0;
    rv = 1'b0;
    rs = '0;
    rd = '0;
    for (int n = 0; n < 200; n++) begin
      if (!hold) begin
        rv = 1'($urandom_range(0, 1));
        rs = SEL_W'($urandom_range(0, 3));
        rd = $urandom;
      end
      rr = 4'($urandom);
      hold = rv && !((sbq[rs].size() == 0) || rr[rs]);
      applyStimulus(rv, rs, rd, rr);
    end
    applyStimulus(1'b0, CH_ALU, 32'h0, 4'b1111);

    $display("[TB] async reset mid-cycle");
    applyStimulus(1'b1, CH_BR, 32'h55, 4'b0000);
    i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    chk("areset_valid", 128'(o_valid), 128'(0));
    chk("areset_data",  128'(o_data),  128'(0));
    chk("areset_ready", 128'(o_ready), 128'(0));
    clearQueues();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    applyStimulus(1'b0, CH_BR, 32'h0, 4'b0000);
    applyStimulus(1'b0, CH_BR, 32'h0, 4'b1111);

`ifdef DEMUX_STATS_EN
    $display("[TB] transfer counters");
    for (int n = 0; n < 17; n++)
      applyStimulus(1'b1, CH_CSR, 32'(n), 4'b1111);
    applyStimulus(1'b0, CH_ALU, 32'h0, 4'b1111);
    chk("cnt0", 128'(o_xfer_cnt[0*CNT_W +: CNT_W]), 128'(0));
    chk("cnt1", 128'(o_xfer_cnt[1*CNT_W +: CNT_W]), 128'(0));
    chk("cnt2", 128'(o_xfer_cnt[2*CNT_W +: CNT_W]), 128'(0));
    chk("cnt3", 128'(o_xfer_cnt[3*CNT_W +: CNT_W]), 128'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
